// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with selectable standard/FWFT read,
// programmable almost-full/almost-empty thresholds, a fill count and
// one-cycle overflow/underflow error pulses.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   data_in, wr_en    write data / write request
//   rd_en             read request (standard) or pop of displayed word (FWFT)
//   data_out          read data (registered in standard mode, combinational in FWFT)
//   empty, full       0 words / DATA_DEPTH words stored
//   almost_full       fill_cnt >= AF_LEVEL
//   almost_empty      fill_cnt <= AE_LEVEL
//   fill_cnt          current word count, 0..DATA_DEPTH
//   overflow          one-cycle pulse after a rejected write
//   underflow         one-cycle pulse after a rejected read
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 16,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          wr_en,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(DATA_DEPTH):0]   fill_cnt,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(DATA_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] DEPTH_L = PW'(DATA_DEPTH);
    localparam logic [PW-1:0] AF_L    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L    = PW'(AE_LEVEL);

    // Elaboration-time parameter checks
    if ((DATA_DEPTH < 2) || ((DATA_DEPTH & (DATA_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_flags: DATA_DEPTH must be a power of two >= 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DATA_DEPTH)) begin : g_bad_af
        $error("sync_fifo_flags: AF_LEVEL out of range 1..DATA_DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DATA_DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_flags: AE_LEVEL out of range 0..DATA_DEPTH-1");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] ram_q [DATA_DEPTH];
    logic                  rd_acc, wr_acc;
    logic [AW-1:0]         wr_addr, rd_addr;

    assign wr_addr = wr_ptr_q[AW-1:0];
    assign rd_addr = rd_ptr_q[AW-1:0];

    // Extra wrap bit makes the modular difference span 0..DATA_DEPTH.
    assign fill_cnt     = wr_ptr_q - rd_ptr_q;
    assign empty        = (fill_cnt == '0);
    assign full         = (fill_cnt == DEPTH_L);
    assign almost_full  = (fill_cnt >= AF_L);
    assign almost_empty = (fill_cnt <= AE_L);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        rd_acc      = rd_en && !empty;
        // A write into a full FIFO is fine when the head leaves the same cycle.
        wr_acc      = wr_en && (!full || rd_acc);
        wr_ptr_d    = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
        overflow_d  = wr_en && !wr_acc;
        underflow_d = rd_en && !rd_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            ram_q[wr_addr] <= data_in;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = empty ? '0 : ram_q[rd_addr];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

        // When full, wr_addr == rd_addr: the non-blocking RAM write lands
        // after this read samples the old head word.
        always_comb begin
            data_out_d = data_out_q;
            if (rd_acc) begin
                data_out_d = ram_q[rd_addr];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_out_q <= '0;
            end else begin
                data_out_q <= data_out_d;
            end
        end

        assign data_out = data_out_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench: a standard-mode and an FWFT-mode instance share one input stream;
// a queue-based model predicts every output of both after each clock.
module tb_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic          wr_en, rd_en;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
    logic          f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
    logic [4:0]    s_cnt, f_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    logic          m_ovf, m_unf;
    bit            full_seen;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FWFT(0),
                      .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(s_dout), .empty(s_empty), .full(s_full), .almost_full(s_af),
        .almost_empty(s_ae), .fill_cnt(s_cnt), .overflow(s_ovf), .underflow(s_unf));

    sync_fifo_flags #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FWFT(1),
                      .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(f_dout), .empty(f_empty), .full(f_full), .almost_full(f_af),
        .almost_empty(f_ae), .fill_cnt(f_cnt), .overflow(f_ovf), .underflow(f_unf));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string ph);
        int sz;
        sz = mq.size();
        chk({ph, " std.cnt"},   32'(s_cnt),   32'(sz));
        chk({ph, " std.empty"}, 32'(s_empty), 32'(sz == 0));
        chk({ph, " std.full"},  32'(s_full),  32'(sz == DEPTH));
        chk({ph, " std.af"},    32'(s_af),    32'(sz >= AF));
        chk({ph, " std.ae"},    32'(s_ae),    32'(sz <= AE));
        chk({ph, " std.ovf"},   32'(s_ovf),   32'(m_ovf));
        chk({ph, " std.unf"},   32'(s_unf),   32'(m_unf));
        chk({ph, " std.dout"},  32'(s_dout),  32'(m_dout));
        chk({ph, " fw.cnt"},    32'(f_cnt),   32'(sz));
        chk({ph, " fw.empty"},  32'(f_empty), 32'(sz == 0));
        chk({ph, " fw.full"},   32'(f_full),  32'(sz == DEPTH));
        chk({ph, " fw.af"},     32'(f_af),    32'(sz >= AF));
        chk({ph, " fw.ae"},     32'(f_ae),    32'(sz <= AE));
        chk({ph, " fw.ovf"},    32'(f_ovf),   32'(m_ovf));
        chk({ph, " fw.unf"},    32'(f_unf),   32'(m_unf));
        chk({ph, " fw.dout"},   32'(f_dout),  (sz == 0) ? 32'd0 : 32'(mq[0]));
    endtask

    // Entered and left just after a falling edge.
    task automatic cyc(input string ph, input bit w, input bit r, input logic [DW-1:0] d);
        bit ra, wa;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        ra = r && (mq.size() != 0);
        wa = w && ((mq.size() < DEPTH) || ra);
        if (ra) m_dout = mq.pop_front();
        if (wa) mq.push_back(d);
        m_ovf = w && !wa;
        m_unf = r && !ra;
        @(negedge clk);
        if (s_full) full_seen = 1'b1;
        chk_all(ph);
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // fill 0x00..0x0F, then one rejected write
        for (int i = 0; i < DEPTH; i++) cyc("fill", 1'b1, 1'b0, 8'(i));
        cyc("overflow", 1'b1, 1'b0, 8'h77);
        cyc("ovf_clear", 1'b0, 1'b0, 8'h00);

        // full with read+write: head leaves, 0xAA goes to the tail
        cyc("full_rw", 1'b1, 1'b1, 8'hAA);

        // drain, then a rejected read keeps data_out
        for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, 1'b1, 8'h00);
        chk("drain.last_is_AA", 32'(s_dout), 32'hAA);
        cyc("underflow", 1'b0, 1'b1, 8'h00);
        cyc("unf_clear", 1'b0, 1'b0, 8'h00);

        // empty with both requests: write only
        cyc("empty_rw", 1'b1, 1'b1, 8'h5C);
        chk("fwft.show_5C", 32'(f_dout), 32'h5C);
        cyc("pop", 1'b0, 1'b1, 8'h00);
        chk("fwft.empty_zero", 32'(f_dout), 32'h0);

        // wrap-around at a fill level of about 3
        full_seen = 1'b0;
        for (int i = 0; i < 3; i++) cyc("wrap_pre", 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 40; i++) cyc("wrap", 1'b1, 1'b1, 8'($urandom));
        chk("wrap.never_full", 32'(full_seen), 32'd0);
        for (int i = 0; i < 3; i++) cyc("wrap_post", 1'b0, 1'b1, 8'h00);

        // random traffic, biased to cover full and empty
        for (int i = 0; i < 300; i++) begin
            bit w, r;
            if (i < 150) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            cyc("random", w, r, 8'($urandom));
        end

        // reset mid-operation at fill 9, observed between clock edges
        while (mq.size() > 9) cyc("to9", 1'b0, 1'b1, 8'h00);
        while (mq.size() < 9) cyc("to9", 1'b1, 1'b0, 8'($urandom));
        wr_en = 1'b0; rd_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        @(negedge clk);
        chk_all("rst_hold");
        rst_n = 1'b1;
        cyc("post_rst", 1'b1, 1'b0, 8'h3C);
        chk("post_rst.cnt1", 32'(s_cnt), 32'd1);
        cyc("post_rst_rd", 1'b0, 1'b1, 8'h00);
        chk("post_rst.data", 32'(s_dout), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
